// File: rtl/scarf_capture_pkg.sv
// Shared types, register addresses and sample-width helpers for the SCARF logic capture block.
package scarf_capture_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StCapture,
      StDone
   } capture_state_t;

   localparam logic [7:0] RegCtrl      = 8'h00;
   localparam logic [7:0] RegEndAddr0  = 8'h01;
   localparam logic [7:0] RegEndAddr1  = 8'h02;
   localparam logic [7:0] RegEndAddr2  = 8'h03;
   localparam logic [7:0] RegCfg       = 8'h04;
   localparam logic [7:0] RegTrigMask  = 8'h05;
   localparam logic [7:0] RegTrigValue = 8'h06;
   localparam logic [7:0] RegStatus    = 8'h07;
   localparam logic [7:0] RegLastAddr0 = 8'h08;
   localparam logic [7:0] RegLastAddr1 = 8'h09;
   localparam logic [7:0] RegLastAddr2 = 8'h0A;

   // Bits per sample: 1/2/4/8 for width_sel 0/1/2/3.
   function automatic logic [3:0] width_bits(input logic [1:0] width_sel);
      return 4'd1 << width_sel;
   endfunction

   function automatic logic [7:0] width_mask(input logic [1:0] width_sel);
      case (width_sel)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/scarf_regmap_capture.sv
// SCARF slave byte protocol, configuration registers and registered read mux for the capture block.
module scarf_regmap_capture
   import scarf_capture_pkg::*;
#(
   parameter logic [6:0] SLAVE_ID = 7'd02
) (
   input  logic        clk,
   input  logic        rst_n_sync,
   input  logic [7:0]  data_in,
   input  logic        data_in_valid,
   input  logic        data_in_finished,
   input  logic [6:0]  slave_id,
   input  logic        rnw,
   output logic [7:0]  read_data_out,
   output logic        enable,
   output logic [18:0] end_addr,
   output logic [2:0]  timestep_sel,
   output logic [1:0]  width_sel,
   output logic [7:0]  trig_mask,
   output logic [7:0]  trig_value,
   input  logic        active,
   input  logic        done,
   input  logic        triggered,
   input  logic [18:0] last_addr
);

   logic        sel;
   logic        phase_q;
   logic [7:0]  ptr_q;
   logic        ctrl_q;
   logic [18:0] end_addr_q;
   logic [4:0]  cfg_q;
   logic [7:0]  mask_q;
   logic [7:0]  value_q;
   logic [7:0]  rdata_d;
   logic [7:0]  rdata_q;

   assign sel = (slave_id == SLAVE_ID);

   always_comb begin
      rdata_d = 8'h00;
      case (ptr_q)
         RegCtrl:      rdata_d = {7'd0, ctrl_q};
         RegEndAddr0:  rdata_d = end_addr_q[7:0];
         RegEndAddr1:  rdata_d = end_addr_q[15:8];
         RegEndAddr2:  rdata_d = {5'd0, end_addr_q[18:16]};
         RegCfg:       rdata_d = {3'd0, cfg_q};
         RegTrigMask:  rdata_d = mask_q;
         RegTrigValue: rdata_d = value_q;
         RegStatus:    rdata_d = {5'd0, triggered, done, active};
         RegLastAddr0: rdata_d = last_addr[7:0];
         RegLastAddr1: rdata_d = last_addr[15:8];
         RegLastAddr2: rdata_d = {5'd0, last_addr[18:16]};
         default:      rdata_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n_sync) begin
         phase_q    <= 1'b0;
         ptr_q      <= 8'h00;
         ctrl_q     <= 1'b0;
         end_addr_q <= '0;
         cfg_q      <= '0;
         mask_q     <= 8'h00;
         value_q    <= 8'h00;
         rdata_q    <= 8'h00;
      end else begin
         if (sel && data_in_valid) begin
            if (!phase_q) begin
               ptr_q   <= data_in;
               phase_q <= 1'b1;
            end else begin
               if (!rnw) begin
                  case (ptr_q)
                     RegCtrl:      ctrl_q             <= data_in[0];
                     RegEndAddr0:  end_addr_q[7:0]    <= data_in;
                     RegEndAddr1:  end_addr_q[15:8]   <= data_in;
                     RegEndAddr2:  end_addr_q[18:16]  <= data_in[2:0];
                     RegCfg:       cfg_q              <= data_in[4:0];
                     RegTrigMask:  mask_q             <= data_in;
                     RegTrigValue: value_q            <= data_in;
                     default:      ;
                  endcase
               end
               ptr_q <= ptr_q + 8'd1;
            end
         end
         // End of transaction wins over a same-cycle byte: next byte is a pointer.
         if (data_in_finished) begin
            phase_q <= 1'b0;
         end
         rdata_q <= sel ? rdata_d : 8'h00;
      end
   end

   assign read_data_out = rdata_q;
   assign enable        = ctrl_q;
   assign end_addr      = end_addr_q;
   assign timestep_sel  = cfg_q[2:0];
   assign width_sel     = cfg_q[4:3];
   assign trig_mask     = mask_q;
   assign trig_value    = value_q;

endmodule

// File: rtl/scarf_logic_capture.sv
// Logic capture top: GPIO synchroniser, trigger, sample timer, byte packer and capture FSM
// driving the SRAM write port.
module scarf_logic_capture
   import scarf_capture_pkg::*;
#(
   parameter logic [6:0] SLAVE_ID = 7'd02
) (
   input  logic        clk,
   input  logic        rst_n_sync,
   input  logic [7:0]  data_in,
   input  logic        data_in_valid,
   input  logic        data_in_finished,
   input  logic [6:0]  slave_id,
   input  logic        rnw,
   output logic [7:0]  read_data_out,
   input  logic [7:0]  gpio_cap_in,
   output logic        capture_active,
   output logic        capture_done,
   output logic [18:0] sram_addr_cap,
   output logic [7:0]  sram_wdata_cap,
   output logic        sram_we_cap
);

   logic        enable;
   logic [18:0] end_addr;
   logic [2:0]  timestep_sel;
   logic [1:0]  width_sel;
   logic [7:0]  trig_mask;
   logic [7:0]  trig_value;

   logic [7:0]  sync1_q, sync2_q;
   capture_state_t state_q, state_d;
   logic [6:0]  tmr_q, tmr_d;
   logic [7:0]  pack_q, pack_d;
   logic [3:0]  bitpos_q, bitpos_d;
   logic [18:0] addr_q, addr_d;
   logic [18:0] last_addr_q;
   logic        we_q, we_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        triggered_q, triggered_d;

   logic [3:0]  width;
   logic [6:0]  tmr_reload;
   logic [7:0]  shifted;
   logic        match;
   logic        last_write;

   scarf_regmap_capture #(
      .SLAVE_ID(SLAVE_ID)
   ) u_regmap (
      .clk             (clk),
      .rst_n_sync      (rst_n_sync),
      .data_in         (data_in),
      .data_in_valid   (data_in_valid),
      .data_in_finished(data_in_finished),
      .slave_id        (slave_id),
      .rnw             (rnw),
      .read_data_out   (read_data_out),
      .enable          (enable),
      .end_addr        (end_addr),
      .timestep_sel    (timestep_sel),
      .width_sel       (width_sel),
      .trig_mask       (trig_mask),
      .trig_value      (trig_value),
      .active          (capture_active),
      .done            (capture_done),
      .triggered       (triggered_q),
      .last_addr       (last_addr_q)
   );

   assign width      = width_bits(width_sel);
   assign tmr_reload = 7'((8'd1 << timestep_sel) - 8'd1);
   assign shifted    = (sync2_q & width_mask(width_sel)) << bitpos_q;
   assign match      = (sync2_q & trig_mask) == (trig_value & trig_mask);
   assign last_write = we_q && (addr_q == end_addr);

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      pack_d      = pack_q;
      bitpos_d    = bitpos_q;
      addr_d      = addr_q;
      triggered_d = triggered_q;
      we_d        = 1'b0;
      wdata_d     = wdata_q;

      // Post-increment after each write; the final address is held, never wrapped.
      if (we_q && !last_write) begin
         addr_d = addr_q + 19'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d     = StArm;
               pack_d      = 8'h00;
               bitpos_d    = 4'd0;
               addr_d      = '0;
               triggered_d = 1'b0;
            end
         end
         StArm: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (match) begin
               state_d     = StCapture;
               triggered_d = 1'b1;
               tmr_d       = 7'd0;
            end
         end
         StCapture: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (last_write) begin
               state_d = StDone;
            end else if (tmr_q == 7'd0) begin
               tmr_d = tmr_reload;
               if (bitpos_q + width == 4'd8) begin
                  we_d     = 1'b1;
                  wdata_d  = pack_q | shifted;
                  pack_d   = 8'h00;
                  bitpos_d = 4'd0;
               end else begin
                  pack_d   = pack_q | shifted;
                  bitpos_d = bitpos_q + width;
               end
            end else begin
               tmr_d = tmr_q - 7'd1;
            end
         end
         StDone: begin
            if (!enable) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n_sync) begin
         sync1_q     <= 8'h00;
         sync2_q     <= 8'h00;
         state_q     <= StIdle;
         tmr_q       <= 7'd0;
         pack_q      <= 8'h00;
         bitpos_q    <= 4'd0;
         addr_q      <= '0;
         last_addr_q <= '0;
         we_q        <= 1'b0;
         wdata_q     <= 8'h00;
         triggered_q <= 1'b0;
      end else begin
         sync1_q     <= gpio_cap_in;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         pack_q      <= pack_d;
         bitpos_q    <= bitpos_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         triggered_q <= triggered_d;
         if (we_q) begin
            last_addr_q <= addr_q;
         end
      end
   end

   assign capture_active = (state_q == StArm) || (state_q == StCapture);
   assign capture_done   = (state_q == StDone);
   assign sram_addr_cap  = addr_q;
   assign sram_wdata_cap = wdata_q;
   assign sram_we_cap    = we_q;

endmodule

// File: tb/tb_scarf_logic_capture.sv
// Scoreboard bench for scarf_logic_capture: expected SRAM writes are queued with their cycle
// offset from the enable write and matched against every observed write strobe.
module tb_scarf_logic_capture;

   localparam logic [6:0] Sid = 7'd02;

   logic        clk = 1'b0;
   logic        rst_n_sync;
   logic [7:0]  data_in;
   logic        data_in_valid;
   logic        data_in_finished;
   logic [6:0]  slave_id;
   logic        rnw;
   logic [7:0]  read_data_out;
   logic [7:0]  gpio_cap_in;
   logic        capture_active;
   logic        capture_done;
   logic [18:0] sram_addr_cap;
   logic [7:0]  sram_wdata_cap;
   logic        sram_we_cap;

   typedef struct {
      logic [18:0] addr;
      logic [7:0]  data;
      int          off;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   base_cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   scarf_logic_capture #(
      .SLAVE_ID(Sid)
   ) dut (
      .clk             (clk),
      .rst_n_sync      (rst_n_sync),
      .data_in         (data_in),
      .data_in_valid   (data_in_valid),
      .data_in_finished(data_in_finished),
      .slave_id        (slave_id),
      .rnw             (rnw),
      .read_data_out   (read_data_out),
      .gpio_cap_in     (gpio_cap_in),
      .capture_active  (capture_active),
      .capture_done    (capture_done),
      .sram_addr_cap   (sram_addr_cap),
      .sram_wdata_cap  (sram_wdata_cap),
      .sram_we_cap     (sram_we_cap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n_sync === 1'b1 && sram_we_cap === 1'b1) begin
         if (sb.size() == 0) begin
            check("we_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("wr_addr", 32'(sram_addr_cap), 32'(e.addr));
            check("wr_data", 32'(sram_wdata_cap), 32'(e.data));
            check("wr_cycle", 32'(cyc - base_cyc), 32'(e.off));
         end
      end
   end

   task automatic push(input logic [18:0] a, input logic [7:0] d, input int off);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.off  = off;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      data_in_finished = 1'b0;
   endtask

   task automatic bus_byte(input logic [7:0] d);
      data_in       = d;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
   endtask

   task automatic bus_end();
      data_in_finished = 1'b1;
      @(negedge clk);
      data_in_finished = 1'b0;
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
      slave_id = Sid;
      rnw      = 1'b0;
      bus_byte(a);
      bus_byte(d);
      bus_end();
   endtask

   task automatic reg_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
      slave_id = Sid;
      rnw      = 1'b1;
      bus_byte(a);
      @(negedge clk);
      check(tag, 32'(read_data_out), 32'(exp));
      bus_end();
   endtask

   task automatic write_end_addr(input logic [18:0] a);
      slave_id = Sid;
      rnw      = 1'b0;
      bus_byte(8'h01);
      bus_byte(a[7:0]);
      bus_byte(a[15:8]);
      bus_byte({5'd0, a[18:16]});
      bus_end();
   endtask

   // Leaves data_in_finished high; the caller's next tick() drops it.
   task automatic enable_capture();
      slave_id = Sid;
      rnw      = 1'b0;
      bus_byte(8'h00);
      bus_byte(8'h01);
      base_cyc         = cyc;
      data_in_finished = 1'b1;
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] vals [4];
      vals[0] = 8'h3A;
      vals[1] = 8'hC5;
      vals[2] = 8'h71;
      vals[3] = 8'h0E;

      rst_n_sync       = 1'b0;
      data_in          = 8'h00;
      data_in_valid    = 1'b0;
      data_in_finished = 1'b0;
      slave_id         = 7'd0;
      rnw              = 1'b0;
      gpio_cap_in      = 8'hEE;
      repeat (3) @(negedge clk);
      check("rst_active", 32'(capture_active), 32'd0);
      check("rst_done", 32'(capture_done), 32'd0);
      check("rst_we", 32'(sram_we_cap), 32'd0);
      check("rst_addr", 32'(sram_addr_cap), 32'd0);
      check("rst_rdata", 32'(read_data_out), 32'd0);
      rst_n_sync = 1'b1;
      tick();

      // 8-bit samples every cycle, four bytes, no trigger condition.
      write_end_addr(19'd3);
      reg_write(8'h04, 8'h18);
      reg_write(8'h05, 8'h00);
      for (int i = 0; i < 4; i++) push(19'(i), vals[i], 3 + i);
      enable_capture();
      for (int i = 0; i < 10; i++) begin
         gpio_cap_in = (i < 4) ? vals[i] : 8'h99;
         tick();
      end
      drain(10, "t1_drain");
      check("t1_done", 32'(capture_done), 32'd1);
      check("t1_active", 32'(capture_active), 32'd0);
      reg_read(8'h07, 8'h06, "t1_status");
      reg_read(8'h08, 8'h03, "t1_last_addr");

      // 1-bit samples every 2 cycles, gpio[0] alternating, upper bits masked off.
      reg_write(8'h00, 8'h00);
      write_end_addr(19'd1);
      reg_write(8'h04, 8'h01);
      gpio_cap_in = 8'hFE;
      push(19'd0, 8'h55, 17);
      push(19'd1, 8'h55, 33);
      enable_capture();
      for (int i = 0; i < 40; i++) begin
         gpio_cap_in = {7'h7F, ((i >> 1) & 1) == 0};
         tick();
      end
      drain(10, "t2_drain");
      check("t2_done", 32'(capture_done), 32'd1);

      // Trigger on gpio[7]; raised at offset 10, so the captured byte is gpio at offset 11.
      reg_write(8'h00, 8'h00);
      write_end_addr(19'd0);
      reg_write(8'h04, 8'h18);
      reg_write(8'h05, 8'h80);
      reg_write(8'h06, 8'h80);
      gpio_cap_in = 8'h00;
      push(19'd0, 8'hC3, 14);
      enable_capture();
      for (int i = 0; i < 20; i++) begin
         if (i < 10) gpio_cap_in = 8'h7F ^ 8'(i);
         else if (i == 10) gpio_cap_in = 8'h80;
         else if (i == 11) gpio_cap_in = 8'hC3;
         else gpio_cap_in = 8'h95;
         if (i == 8) begin
            check("t3_armed", 32'(capture_active), 32'd1);
            check("t3_not_done", 32'(capture_done), 32'd0);
         end
         tick();
      end
      drain(10, "t3_drain");
      check("t3_done", 32'(capture_done), 32'd1);
      reg_read(8'h07, 8'h06, "t3_status");
      reg_read(8'h08, 8'h00, "t3_last_addr");

      // 4-bit samples every 8 cycles; abort mid second byte, then rerun from address 0.
      reg_write(8'h00, 8'h00);
      write_end_addr(19'd5);
      reg_write(8'h04, 8'h13);
      reg_write(8'h05, 8'h00);
      gpio_cap_in = 8'h0F;
      push(19'd0, 8'h6A, 11);
      enable_capture();
      for (int i = 0; i < 14; i++) begin
         gpio_cap_in = (i == 0) ? 8'h5A : (i == 8) ? 8'h96 : 8'h0F;
         tick();
      end
      reg_write(8'h00, 8'h00);
      repeat (40) tick();
      drain(2, "t4_drain");
      check("t4_abort_active", 32'(capture_active), 32'd0);
      check("t4_abort_done", 32'(capture_done), 32'd0);
      reg_read(8'h07, 8'h04, "t4_abort_status");
      gpio_cap_in = 8'h3C;
      for (int k = 0; k < 6; k++) push(19'(k), 8'hCC, 11 + 16 * k);
      enable_capture();
      drain(150, "t4_rerun_drain");
      tick();
      tick();
      check("t4_rerun_done", 32'(capture_done), 32'd1);

      // Register map readback and access rules.
      reg_read(8'h00, 8'h01, "rd_ctrl");
      reg_read(8'h01, 8'h05, "rd_end0");
      reg_read(8'h02, 8'h00, "rd_end1");
      reg_read(8'h03, 8'h00, "rd_end2");
      reg_read(8'h04, 8'h13, "rd_cfg");
      reg_read(8'h05, 8'h00, "rd_mask");
      reg_read(8'h06, 8'h80, "rd_value");
      reg_read(8'h07, 8'h06, "rd_status");
      reg_read(8'h08, 8'h05, "rd_last0");
      reg_read(8'h09, 8'h00, "rd_last1");
      reg_read(8'h0A, 8'h00, "rd_last2");
      reg_read(8'h0B, 8'h00, "rd_unmapped");
      reg_write(8'h03, 8'hFF);
      reg_read(8'h03, 8'h07, "rd_end2_trunc");
      reg_write(8'h07, 8'hFF);
      reg_read(8'h07, 8'h06, "rd_status_ro");
      slave_id = 7'd5;
      rnw      = 1'b0;
      bus_byte(8'h05);
      bus_byte(8'h5A);
      bus_end();
      reg_read(8'h05, 8'h00, "rd_other_slave_wr");
      slave_id = 7'd5;
      rnw      = 1'b1;
      bus_byte(8'h04);
      @(negedge clk);
      check("rd_other_slave_rd", 32'(read_data_out), 32'd0);
      bus_end();
      slave_id = Sid;
      rnw      = 1'b1;
      bus_byte(8'h05);
      bus_byte(8'h00);
      @(negedge clk);
      check("rd_ptr_incr", 32'(read_data_out), 32'h80);
      bus_end();

      // Synchronous reset while capturing.
      reg_write(8'h00, 8'h00);
      write_end_addr(19'd5);
      reg_write(8'h04, 8'h1F);
      gpio_cap_in = 8'h6B;
      push(19'd0, 8'h6B, 3);
      enable_capture();
      repeat (10) tick();
      check("t6_pre_active", 32'(capture_active), 32'd1);
      check("t6_pre_addr", 32'(sram_addr_cap), 32'd1);
      check("t6_pre_wdata", 32'(sram_wdata_cap), 32'h6B);
      rst_n_sync = 1'b0;
      tick();
      check("t6_active", 32'(capture_active), 32'd0);
      check("t6_done", 32'(capture_done), 32'd0);
      check("t6_we", 32'(sram_we_cap), 32'd0);
      check("t6_addr", 32'(sram_addr_cap), 32'd0);
      check("t6_wdata", 32'(sram_wdata_cap), 32'd0);
      check("t6_rdata", 32'(read_data_out), 32'd0);
      rst_n_sync = 1'b1;
      repeat (2) tick();
      drain(1, "t6_drain");
      reg_read(8'h00, 8'h00, "t6_ctrl");
      reg_read(8'h01, 8'h00, "t6_end0");
      reg_read(8'h04, 8'h00, "t6_cfg");
      reg_read(8'h06, 8'h00, "t6_value");
      reg_read(8'h07, 8'h00, "t6_status");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/scarf_logic_capture.md
# scarf_logic_capture

Capture counterpart to the SCARF pattern generator. It samples up to 8 GPIO inputs at a programmable timestep, waits for an optional trigger, packs the samples into bytes and writes them to SRAM from address 0 up to a programmed end address. It is configured and polled through its own SCARF slave register map, on the same byte-stream bus as the pattern generator, and owns the SRAM write port while capturing.

## Interface
- SLAVE_ID, 7'd02, SCARF slave address this block responds to.
- clk  in  1  single clock for the whole block.
- rst_n_sync  in  1  reset, synchronous and active-low.
- data_in  in  8  SCARF byte from the bus deserialiser.
- data_in_valid  in  1  one-cycle strobe; data_in is valid.
- data_in_finished  in  1  one-cycle strobe; the transaction has ended.
- slave_id  in  7  addressed slave of the current transaction.
- rnw  in  1  1 = read transaction, 0 = write.
- read_data_out  out  8  register read data; 0 when not addressed.
- gpio_cap_in  in  8  asynchronous GPIO inputs.
- capture_active  out  1  state is ARM or CAPTURE.
- capture_done  out  1  state is DONE.
- sram_addr_cap  out  19  SRAM write address.
- sram_wdata_cap  out  8  SRAM write data.
- sram_we_cap  out  1  one-cycle write strobe; the SRAM accepts one write per cycle.

## Operation
- Register access applies only when slave_id == SLAVE_ID:
  - The first data_in_valid byte of a transaction loads the register pointer.
  - Each later byte writes the register at the pointer (rnw=0), or advances the read (rnw=1). The pointer then increments by 1.
  - data_in_finished resets the byte phase to "expect pointer".
- Register map (all default 0):
  - 0x00 ctrl: [0] enable.
  - 0x01–0x03 end_addr[18:0], little-endian; bits above 18 are ignored.
  - 0x04 cfg: [2:0] timestep_sel, [4:3] width_sel.
  - 0x05 trig_mask.
  - 0x06 trig_value.
  - 0x07 status (RO): [0] active, [1] done, [2] triggered.
  - 0x08–0x0A last written address (RO).
  - Other addresses read 0; writes to them are ignored.
- gpio_cap_in passes through a 2-flop synchroniser. All sampling and trigger comparison uses the synchronised value.
- Sample period is 2^timestep_sel clocks (1..128).
- Sample width is 1/2/4/8 bits for width_sel 0/1/2/3, taken from the low bits. Samples pack LSB-first, so one byte holds 8/width samples.
- FSM:
  - IDLE: enable=1 → ARM. Clears the packer, address and triggered bit.
  - ARM: (sync & trig_mask) == (trig_value & trig_mask) → CAPTURE and set triggered. trig_mask=0 triggers in the first ARM cycle.
  - CAPTURE: take samples at the period; write each completed byte.
  - After the byte at end_addr is written → DONE.
  - DONE: hold until enable=0 → IDLE.
  - enable=0 in ARM or CAPTURE → IDLE immediately. A partially packed byte is discarded and capture_done is not set.
- Addresses run 0..end_addr with no wrap. end_addr=0 captures exactly one byte.
- A write to ctrl in the same cycle as an FSM transition: the register write takes effect first and the FSM sees the new value next cycle.

## Timing
- Reset values:
  - All outputs 0 and all registers 0; state IDLE.
  - The synchroniser flops are cleared.
- gpio latency: a pin change is visible to trigger/sample logic 2 cycles later.
- Trigger match in ARM cycle N → state CAPTURE at N+1. The first sample is taken at N+1, then every 2^timestep_sel cycles.
- A byte completed by the sample at cycle M is written at M+1:
  - sram_we_cap=1 for exactly that cycle, with sram_addr_cap and sram_wdata_cap valid.
  - The address increments after the write.
- After the end_addr write at cycle W: capture_done=1 and capture_active=0 from W+1.
- read_data_out is registered. It reflects the register at the current pointer one cycle after each pointer load or increment.

## Structure
- A shared package scarf_capture_pkg holds:
  - the capture_state_t enum (IDLE, ARM, CAPTURE, DONE);
  - the register address localparams;
  - the width-decode function.
- Sub-module scarf_regmap_capture holds the SCARF byte protocol, the register storage and the read mux. The top holds the synchroniser, trigger, sample timer, packer and FSM.

## Test plan
- Config: write end_addr=3, cfg=0x18 (8-bit, ts=0), mask=0, then enable=1 → 4 SRAM writes at addresses 0..3 on consecutive cycles, each equal to gpio 2 cycles earlier; then capture_done=1 and status reads 0x06.
- Packing: width_sel=0 (1-bit), ts=1, gpio[0] toggling each sample → wdata=0x55 every 16 cycles.
- Trigger: mask=0x80, value=0x80, gpio[7] raised at cycle 50 → no writes before it; CAPTURE from cycle 53.
- Abort: enable=0 mid-byte → no further sram_we_cap; state IDLE; capture_done=0; re-enable restarts at address 0.
- Register access: readback of 0x00–0x0A; write to a different slave_id → no change and read_data_out=0.
- Reset: rst_n_sync low during CAPTURE → all outputs 0 next cycle; registers back to default.
